divider_iterative: RTL and testbench



---
 rtl/divider_iterative.sv | 159 +++++++++++++++
 tb/tb_divider_iterative.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/divider_iterative.sv
// Iterative restoring divider: one quotient bit per clock, WIDTH cycles per result.
// Define DIVIDER_SIGNED_EN to add the is_signed port for two's-complement operands.
module divider_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef DIVIDER_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // The load step is the start edge itself, so it needs no state of its own.
  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg_quo_load;
  logic             neg_rem_load;

  // Operand conditioning: the core always divides magnitudes.
  always_comb begin
    a_mag        = a;
    b_mag        = b;
    neg_quo_load = 1'b0;
    neg_rem_load = 1'b0;
`ifdef DIVIDER_SIGNED_EN
    if (is_signed) begin
      if (a[WIDTH-1]) a_mag = -a;
      if (b[WIDTH-1]) b_mag = -b;
      // Divide by zero keeps q all ones; the remainder sign restores r = a.
      neg_quo_load = (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
      neg_rem_load = a[WIDTH-1];
    end
`endif
  end

  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    qbit      = ~diff[WIDTH];
    rem_next  = qbit ? diff : rem_shift;
    quo_next  = {quo_q[WIDTH-2:0], qbit};
  end

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    q_d       = q_q;
    r_d       = r_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    // A start wins in every state and discards any operation in flight.
    if (valid_in) begin
      state_d   = ITER;
      dvd_d     = a_mag;
      dvs_d     = b_mag;
      rem_d     = '0;
      quo_d     = '0;
      cnt_d     = '0;
      busy_d    = 1'b1;
      valid_d   = 1'b0;
      neg_quo_d = neg_quo_load;
      neg_rem_d = neg_rem_load;
    end else begin
      case (state_q)
        ITER: begin
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            q_d     = neg_quo_q ? -quo_next : quo_next;
            r_d     = neg_rem_q ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      q_q       <= q_d;
      r_q       <= r_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy      = busy_q;
  assign valid_out = valid_q;
  assign q         = q_q;
  assign r         = r_q;

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench for divider_iterative: directed corner cases plus random
// operands compared against a plain-arithmetic reference model.
module tb_divider_iterative;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             valid_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             busy;
  logic             valid_out;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  int checks;
  int fails;

  divider_iterative #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
`ifdef DIVIDER_SIGNED_EN
    .is_signed (is_signed),
`endif
    .busy      (busy),
    .valid_out (valid_out),
    .q         (q),
    .r         (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: ordinary division, with the divide-by-zero result defined as q = ~0, r = a.
  function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic sg);
    longint sa, sb, qq, rr;
    if (mb == 32'd0) return {32'hFFFF_FFFF, ma};
    if (!sg) return {ma / mb, ma % mb};
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    qq = sa / sb;
    rr = sa % sb;
    return {qq[31:0], rr[31:0]};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] sa, input logic [31:0] sb, input logic sg);
    @(negedge clk);
    a         = sa;
    b         = sb;
    is_signed = sg;
    valid_in  = 1'b1;
    @(negedge clk);
    valid_in  = 1'b0;
    a         = $urandom;
    b         = $urandom;
  endtask

  // Called right after apply_stimulus; the result must appear exactly WIDTH edges after the start.
  task automatic wait_result(input string tag, input logic [31:0] sa, input logic [31:0] sb,
                             input logic sg);
    logic [63:0] exp;
    logic        early;
    exp   = model(sa, sb, sg);
    early = 1'b0;
    for (int k = 1; k < WIDTH; k++) begin
      @(negedge clk);
      if (valid_out !== 1'b0 || busy !== 1'b1) early = 1'b1;
    end
    @(negedge clk);
    check_output({tag, "_early"}, {31'd0, early}, 32'd0);
    check_output({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_output({tag, "_q"}, q, exp[63:32]);
    check_output({tag, "_r"}, r, exp[31:0]);
  endtask

  task automatic run_op(input string tag, input logic [31:0] sa, input logic [31:0] sb,
                        input logic sg);
    apply_stimulus(sa, sb, sg);
    wait_result(tag, sa, sb, sg);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        held_ok;
    checks    = 0;
    fails     = 0;
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;

    #12;
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_valid", {31'd0, valid_out}, 32'd0);
    check_output("reset_q", q, 32'd0);
    check_output("reset_r", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("div_100_7", 32'd100, 32'd7, 1'b0);
    held_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (valid_out !== 1'b1 || q !== 32'd14 || r !== 32'd2) held_ok = 1'b0;
    end
    check_output("result_held", {31'd0, held_ok}, 32'd1);

    run_op("max_by_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("max_by_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("a_lt_b", 32'd3, 32'd10, 1'b0);
    run_op("div_zero", 32'd5, 32'd0, 1'b0);

    // Restart mid-operation: the first result must never be shown.
    apply_stimulus(32'd1000, 32'd3, 1'b0);
    held_ok = 1'b1;
    repeat (9) begin
      @(negedge clk);
      if (valid_out !== 1'b0) held_ok = 1'b0;
    end
    check_output("restart_no_valid", {31'd0, held_ok}, 32'd1);
    apply_stimulus(32'd81, 32'd9, 1'b0);
    wait_result("restart", 32'd81, 32'd9, 1'b0);

    // Asynchronous reset in the middle of an operation.
    apply_stimulus(32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_busy", {31'd0, busy}, 32'd0);
    check_output("abort_valid", {31'd0, valid_out}, 32'd0);
    check_output("abort_q", q, 32'd0);
    check_output("abort_r", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    held_ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0 || valid_out !== 1'b0) held_ok = 1'b0;
    end
    check_output("idle_after_reset", {31'd0, held_ok}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? ($urandom & 32'hFF) : ($urandom >> (i % 28));
      run_op("rand_u", ra, rb, 1'b0);
    end

`ifdef DIVIDER_SIGNED_EN
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op("s_div_zero", 32'hFFFF_FFF0, 32'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom >> (i % 30);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_op("rand_s", ra, rb, 1'b1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
